// File: rtl/rf_wb_scheduler_if.sv
// Writeback/scoreboard bundle between execute, LSU, issue and the register file.
// Handshake: a write transfers in the cycle where reqN_valid_i & reqN_ready_o are both 1;
// a requester that sees valid=1 and ready=0 must hold valid, addr and data stable.
interface rf_wb_scheduler_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [ADDR_W-1:0] req0_addr_i;
    logic [DATA_W-1:0] req0_data_i;
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [ADDR_W-1:0] req1_addr_i;
    logic [DATA_W-1:0] req1_data_i;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic              alloc_valid_i;
    logic [ADDR_W-1:0] alloc_addr_i;
    logic              alloc_stall_o;
    logic [ADDR_W-1:0] rs1_addr_i;
    logic [ADDR_W-1:0] rs2_addr_i;
    logic              hazard_o;
    logic              byp1_o;
    logic              byp2_o;

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_addr_i, req1_data_i,
        output alloc_valid_i, alloc_addr_i, rs1_addr_i, rs2_addr_i,
        input  req0_ready_o, req1_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        input  alloc_stall_o, hazard_o, byp1_o, byp2_o
    );

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        input  alloc_valid_i, alloc_addr_i, rs1_addr_i, rs2_addr_i,
        output req0_ready_o, req1_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        output alloc_stall_o, hazard_o, byp1_o, byp2_o
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Round-robin arbiter for the single RF write port plus a per-register busy scoreboard.
// Optional macro RF_BYPASS_EN forwards the registered write data to the issue sources.
module rf_wb_scheduler #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int PRIO_INIT = 0
) (
    input logic              clk_i,
    input logic              rst_ni,
    rf_wb_scheduler_if.slave bus
);
    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {PRIO_REQ0 = 1'b0, PRIO_REQ1 = 1'b1} prio_e;

    prio_e             prio_q;
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_set;
    logic [NREGS-1:0]  busy_clr;
    logic              byp1, byp2;

    always_comb begin
        gnt0     = bus.req0_valid_i & (~bus.req1_valid_i | (prio_q == PRIO_REQ0));
        gnt1     = bus.req1_valid_i & ~gnt0;
        gnt_addr = gnt1 ? bus.req1_addr_i : bus.req0_addr_i;
        gnt_data = gnt1 ? bus.req1_data_i : bus.req0_data_i;
    end

    // A grant to x0 completes the handshake but never raises the write enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= (PRIO_INIT != 0) ? PRIO_REQ1 : PRIO_REQ0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= (gnt0 | gnt1) & (gnt_addr != '0);
            if (gnt0 | gnt1) begin
                prio_q     <= gnt0 ? PRIO_REQ1 : PRIO_REQ0;
                rf_waddr_q <= gnt_addr;
                rf_wdata_q <= gnt_data;
            end
        end
    end

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (bus.alloc_valid_i && (bus.alloc_addr_i != '0)) busy_set[bus.alloc_addr_i] = 1'b1;
        if (rf_we_q) busy_clr[rf_waddr_q] = 1'b1;
    end

    // Set applied after clear so a new producer wins over a retiring one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= (busy_q & ~busy_clr) | busy_set;
    end

`ifdef RF_BYPASS_EN
    assign byp1 = rf_we_q & (rf_waddr_q == bus.rs1_addr_i) & (bus.rs1_addr_i != '0);
    assign byp2 = rf_we_q & (rf_waddr_q == bus.rs2_addr_i) & (bus.rs2_addr_i != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign bus.req0_ready_o  = gnt0;
    assign bus.req1_ready_o  = gnt1;
    assign bus.rf_we_o       = rf_we_q;
    assign bus.rf_waddr_o    = rf_waddr_q;
    assign bus.rf_wdata_o    = rf_wdata_q;
    assign bus.alloc_stall_o = busy_q[bus.alloc_addr_i];
    assign bus.byp1_o        = byp1;
    assign bus.byp2_o        = byp2;
    assign bus.hazard_o      = ((bus.rs1_addr_i != '0) & busy_q[bus.rs1_addr_i] & ~byp1)
                             | ((bus.rs2_addr_i != '0) & busy_q[bus.rs2_addr_i] & ~byp2);
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed scenarios followed by randomized traffic, compared against a reference model.
module tb_rf_wb_scheduler;
  localparam int AW = 5;
  localparam int DW = 32;

  // clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  rf_wb_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rf_wb_scheduler #(.ADDR_W(AW), .DATA_W(DW), .PRIO_INIT(0)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: busy set per register, writes awaiting presentation, priority owner
  bit                 m_busy[32];
  int                 m_prio;
  bit                 m_g0, m_g1;
  logic [AW+DW-1:0]   exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req0_valid_i  = 1'b0; bus.req0_addr_i = '0; bus.req0_data_i = '0;
    bus.req1_valid_i  = 1'b0; bus.req1_addr_i = '0; bus.req1_data_i = '0;
    bus.alloc_valid_i = 1'b0; bus.alloc_addr_i = '0;
    bus.rs1_addr_i    = '0;   bus.rs2_addr_i  = '0;
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    exp_q.delete();
    m_prio = 0;
  endtask

  // Called with inputs already driven; checks every output, then advances one clock.
  task automatic cycle();
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    wa, rs1, rs2, aa;
    logic [DW-1:0]    wd;
    bit               b1, b2, hz, pend;
    #1;
    rs1  = bus.rs1_addr_i;
    rs2  = bus.rs2_addr_i;
    aa   = bus.alloc_addr_i;
    m_g0 = bus.req0_valid_i && (!bus.req1_valid_i || m_prio == 0);
    m_g1 = bus.req1_valid_i && !m_g0;
    pend = exp_q.size() != 0;
    e    = pend ? exp_q[0] : '0;
    wa   = e[AW+DW-1:DW];
    check("ready0", bus.req0_ready_o, m_g0);
    check("ready1", bus.req1_ready_o, m_g1);
    check("rf_we", bus.rf_we_o, pend);
    if (pend) begin
      check("rf_waddr", bus.rf_waddr_o, wa);
      check("rf_wdata", bus.rf_wdata_o, e[DW-1:0]);
    end
`ifdef RF_BYPASS_EN
    b1 = pend && wa == rs1 && rs1 != 0;
    b2 = pend && wa == rs2 && rs2 != 0;
`else
    b1 = 1'b0;
    b2 = 1'b0;
`endif
    hz = (rs1 != 0 && m_busy[rs1] && !b1) || (rs2 != 0 && m_busy[rs2] && !b2);
    check("byp1", bus.byp1_o, b1);
    check("byp2", bus.byp2_o, b2);
    check("hazard", bus.hazard_o, hz);
    check("alloc_stall", bus.alloc_stall_o, m_busy[aa]);
    @(posedge clk_i);
    if (pend) begin
      e = exp_q.pop_front();
      m_busy[e[AW+DW-1:DW]] = 1'b0;
    end
    if (bus.alloc_valid_i && aa != 0) m_busy[aa] = 1'b1;
    if (m_g0 || m_g1) begin
      wa = m_g0 ? bus.req0_addr_i : bus.req1_addr_i;
      wd = m_g0 ? bus.req0_data_i : bus.req1_data_i;
      if (wa != 0) exp_q.push_back({wa, wd});
      m_prio = m_g0 ? 1 : 0;
    end
    #1;
  endtask

  task automatic mid_reset(input logic [AW-1:0] rs);
    drive_idle();
    bus.rs1_addr_i = rs;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_we", bus.rf_we_o, 1'b0);
    check("rst_waddr", bus.rf_waddr_o, 0);
    check("rst_wdata", bus.rf_wdata_o, 0);
    check("rst_hazard", bus.hazard_o, 1'b0);
    check("rst_ready0", bus.req0_ready_o, 1'b0);
    check("rst_ready1", bus.req1_ready_o, 1'b0);
    model_reset();
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    cycle();
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] busy_pick;
    model_reset();
    drive_idle();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    check("init_we", bus.rf_we_o, 1'b0);
    check("init_waddr", bus.rf_waddr_o, 0);
    check("init_wdata", bus.rf_wdata_o, 0);

    // reset with x5 busy and a write in flight
    bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd5;
    cycle();
    drive_idle();
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd7; bus.req0_data_i = 32'h1234_5678;
    cycle();
    mid_reset(5'd5);
    cycle();

    // both valid from reset: grants alternate 0,1,0,1
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd1; bus.req0_data_i = 32'hAAAA_0001;
    bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd2; bus.req1_data_i = 32'hBBBB_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", bus.req0_ready_o, (i % 2) == 0);
      check("rr_ready1", bus.req1_ready_o, (i % 2) == 1);
      cycle();
    end
    drive_idle();
    cycle();

    // single req0 write: N+1 presents, N+2 idle
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd7; bus.req0_data_i = 32'hDEAD_BEEF;
    #1 check("t2_ready", bus.req0_ready_o, 1'b1);
    cycle();
    drive_idle();
    #1;
    check("t2_we", bus.rf_we_o, 1'b1);
    check("t2_waddr", bus.rf_waddr_o, 7);
    check("t2_wdata", bus.rf_wdata_o, 32'hDEAD_BEEF);
    cycle();
    #1 check("t2_we_off", bus.rf_we_o, 1'b0);
    cycle();

    // RAW on x3 resolved by req1 writeback
    bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd3;
    cycle();
    drive_idle();
    bus.rs1_addr_i = 5'd3;
    bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd3; bus.req1_data_i = 32'h0000_0333;
    #1 check("t4_hazard_n", bus.hazard_o, 1'b1);
    cycle();
    bus.req1_valid_i = 1'b0;
    #1;
`ifdef RF_BYPASS_EN
    check("t4_hazard_n1", bus.hazard_o, 1'b0);
    check("t4_byp1_n1", bus.byp1_o, 1'b1);
`else
    check("t4_hazard_n1", bus.hazard_o, 1'b1);
    check("t4_byp1_n1", bus.byp1_o, 1'b0);
`endif
    cycle();
    #1 check("t4_hazard_n2", bus.hazard_o, 1'b0);
    cycle();
    drive_idle();

    // same-edge clear and set of x9: new producer wins
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd9; bus.req0_data_i = 32'h9999_9999;
    cycle();
    drive_idle();
    bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd9;
    #1 check("t5_we", bus.rf_we_o, 1'b1);
    cycle();
    bus.alloc_valid_i = 1'b0;
    #1 check("t5_stall", bus.alloc_stall_o, 1'b1);
    cycle();

    // write to x0 is accepted but never reaches the RF
    drive_idle();
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd0; bus.req0_data_i = 32'h1;
    #1;
    check("t6_ready", bus.req0_ready_o, 1'b1);
    check("t6_hazard", bus.hazard_o, 1'b0);
    cycle();
    bus.req0_valid_i = 1'b0;
    #1;
    check("t6_we", bus.rf_we_o, 1'b0);
    check("t6_hazard1", bus.hazard_o, 1'b0);
    cycle();

    // randomized traffic; losers hold their request, allocs only when legal
    drive_idle();
    for (int i = 0; i < 400; i++) begin
      if (!(bus.req0_valid_i && !m_g0)) begin
        bus.req0_valid_i = ($urandom_range(0, 2) != 0);
        bus.req0_addr_i  = AW'($urandom_range(0, 9));
        bus.req0_data_i  = $urandom;
      end
      if (!(bus.req1_valid_i && !m_g1)) begin
        bus.req1_valid_i = ($urandom_range(0, 2) != 0);
        bus.req1_addr_i  = AW'($urandom_range(0, 9));
        bus.req1_data_i  = $urandom;
      end
      a = AW'($urandom_range(0, 9));
      bus.alloc_addr_i  = a;
      bus.alloc_valid_i = ($urandom_range(0, 1) == 1) && !m_busy[a];
      bus.rs1_addr_i    = AW'($urandom_range(0, 9));
      bus.rs2_addr_i    = AW'($urandom_range(0, 31));
      cycle();
    end

    busy_pick = 5'd0;
    for (int r = 1; r < 32; r++) if (m_busy[r]) busy_pick = AW'(r);
    mid_reset(busy_pick);
    drive_idle();
    bus.rs1_addr_i = busy_pick;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
